// File: rtl/rect_draw_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | rect_draw_arbiter_pkg                                                |
// | Shared snake-game screen geometry, widths and draw FSM encoding.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rect_draw_arbiter_pkg;

  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int CW      = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/UpDn_count.sv
// +----------------------------------------------------------------------+
// | UpDn_count                                                           |
// | Loadable up/down counter; load has priority over count enable.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module UpDn_count #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_updn,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (!i_resetn)
      o_q <= '0;
    else if (i_load)
      o_q <= i_d;
    else if (i_en)
      o_q <= i_updn ? o_q + 1'b1 : o_q - 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/rect_draw_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Round-robin pick: first asserted request at or above the pointer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import rect_draw_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_p,
  output logic [NREQ-1:0] o_winner,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  int w_j;

  always_comb begin
    o_winner = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = int'(i_p) + i;
      if (w_j >= NREQ)
        w_j = w_j - NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any         = 1'b1;
        o_winner[w_j] = 1'b1;
        o_idx         = PW'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rect_draw_arbiter.sv
// +----------------------------------------------------------------------+
// | rect_draw_arbiter                                                    |
// | Grants one requester at a time and rasters its rectangle to the VGA. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rect_draw_arbiter
  import rect_draw_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XDIM = 10,
  parameter int YDIM = 10
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic [NREQ-1:0]    req,
  input  logic [XW*NREQ-1:0] req_x,
  input  logic [YW*NREQ-1:0] req_y,
  input  logic [CW*NREQ-1:0] req_colour,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [XW-1:0]      vga_x,
  output logic [YW-1:0]      vga_y,
  output logic [CW-1:0]      vga_colour,
  output logic               plot
);

  localparam int PW  = cw(NREQ);
  localparam int XCW = cw(XDIM);
  localparam int YCW = cw(YDIM);

  state_t          r_state;
  logic [PW-1:0]   r_p;
  logic [PW-1:0]   r_idx;
  logic [NREQ-1:0] r_win;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_c;

  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [XCW-1:0]  w_xc;
  logic [YCW-1:0]  w_yc;
  logic            w_draw;
  logic            w_xend;
  logic            w_yend;
  logic            w_last;
  logic [XW:0]     w_sx;
  logic [YW:0]     w_sy;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req    (req),
    .i_p      (r_p),
    .o_winner (w_win),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_draw = (r_state == S_DRAW);
  assign w_xend = (w_xc == XCW'(XDIM - 1));
  assign w_yend = (w_yc == YCW'(YDIM - 1));
  assign w_last = w_draw && w_xend && w_yend;

  // Counters sit at zero outside DRAW so the first pixel is ready on grant.
  UpDn_count #(.N(XCW)) u_xc (
    .i_clk    (CLOCK_50),
    .i_resetn (Resetn),
    .i_en     (w_draw),
    .i_load   (!w_draw || w_xend),
    .i_updn   (1'b1),
    .i_d      ('0),
    .o_q      (w_xc)
  );

  UpDn_count #(.N(YCW)) u_yc (
    .i_clk    (CLOCK_50),
    .i_resetn (Resetn),
    .i_en     (w_draw && w_xend),
    .i_load   (!w_draw || w_last),
    .i_updn   (1'b1),
    .i_d      ('0),
    .o_q      (w_yc)
  );

  assign w_sx = {1'b0, r_x} + (XW+1)'(w_xc);
  assign w_sy = {1'b0, r_y} + (YW+1)'(w_yc);

  assign vga_x      = w_draw ? w_sx[XW-1:0] : '0;
  assign vga_y      = w_draw ? w_sy[YW-1:0] : '0;
  assign vga_colour = w_draw ? r_c : '0;
  assign plot       = w_draw && (w_sx < (XW+1)'(XSCREEN)) && (w_sy < (YW+1)'(YSCREEN));

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_idx   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_DRAW;
            r_busy  <= 1'b1;
            r_gnt   <= w_win;
            r_win   <= w_win;
            r_idx   <= w_idx;
            r_x     <= req_x[int'(w_idx)*XW +: XW];
            r_y     <= req_y[int'(w_idx)*YW +: YW];
            r_c     <= req_colour[int'(w_idx)*CW +: CW];
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= r_win;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_p     <= (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rect_draw_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_rect_draw_arbiter                                                 |
// | Directed vector table plus arbitration/reset sequences.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rect_draw_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        Resetn   = 1'b0;
  logic [2:0]  req      = '0;
  logic [23:0] req_x    = '0;
  logic [20:0] req_y    = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;

  int n_total = 0;
  int n_bad   = 0;

  rect_draw_arbiter #(.NREQ(3), .XDIM(10), .YDIM(10)) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int idx; int x; int y; int c;
    int fx; int fy; int lx; int ly; int plots;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input int x, input int y, input int c);
    req_x[8*idx +: 8]      = 8'(x);
    req_y[7*idx +: 7]      = 7'(y);
    req_colour[3*idx +: 3] = 3'(c);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [2:0] oh;
    int k, plots, busyc, colbad, fx, fy, lx, ly;
    oh = 3'b001 << v.idx;
    set_req(v.idx, v.x, v.y, v.c);
    req = oh;
    step();
    chk("gnt", gnt, oh);
    fx = vga_x;
    fy = vga_y;
    // Disturb the inputs after the grant; the draw must not notice.
    req = '0;
    set_req(v.idx, v.x ^ 8'h55, v.y ^ 7'h2a, v.c ^ 3'b111);
    k = 0; plots = 0; busyc = 0; colbad = 0; lx = fx; ly = fy;
    while (done == 3'b000 && k < 300) begin
      busyc += int'(busy);
      plots += int'(plot);
      if (vga_colour != 3'(v.c)) colbad++;
      lx = vga_x;
      ly = vga_y;
      step();
      k++;
    end
    busyc += int'(busy);
    chk("first_x", fx, v.fx);
    chk("first_y", fy, v.fy);
    chk("last_x", lx, v.lx);
    chk("last_y", ly, v.ly);
    chk("plot_count", plots, v.plots);
    chk("done_latency", k, 100);
    chk("done_onehot", done, oh);
    chk("busy_cycles", busyc, 101);
    chk("colour_errors", colbad, 0);
    chk("plot_in_done", plot, 0);
    step();
    chk("busy_idle", busy, 0);
    chk("vga_x_idle", vga_x, 0);
    chk("vga_colour_idle", vga_colour, 0);
  endtask

  function automatic int oh2i(input logic [2:0] v);
    for (int i = 0; i < 3; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int gcyc[$];
    int gidx[$];
    int k, pixbad;

    vecs[0] = '{0,  39,  59, 2,  39,  59,  48,  68, 100};
    vecs[1] = '{2, 155, 115, 7, 155, 115, 164, 124,  25};
    vecs[2] = '{1, 152, 112, 5, 152, 112, 161, 121,  64};
    vecs[3] = '{1,   0,   0, 1,   0,   0,   9,   9, 100};
    vecs[4] = '{0, 150, 110, 3, 150, 110, 159, 119, 100};
    vecs[5] = '{2, 160,   0, 4, 160,   0, 169,   9,   0};

    // Reset state
    Resetn = 1'b0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    Resetn = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // All three requesting from reset: rotation 0,1,2,0 every 102 cycles.
    Resetn = 1'b0;
    req = 3'b111;
    step();
    Resetn = 1'b1;
    for (int c = 1; c <= 330; c++) begin
      step();
      if (gnt != 3'b000) begin
        gcyc.push_back(c);
        gidx.push_back(oh2i(gnt));
      end
    end
    req = '0;
    chk("rr_gnt_count", gcyc.size() >= 4, 1);
    if (gcyc.size() >= 4) begin
      chk("rr_order0", gidx[0], 0);
      chk("rr_order1", gidx[1], 1);
      chk("rr_order2", gidx[2], 2);
      chk("rr_order3", gidx[3], 0);
      chk("rr_first_cycle", gcyc[0], 1);
      for (int i = 1; i < 4; i++)
        chk("rr_gap", gcyc[i] - gcyc[i-1], 102);
    end
    wait_idle();
    step();

    // Requester 2 alone; requester 0 arrives mid-draw; x of 2 changes mid-draw.
    set_req(2, 20, 30, 5);
    req = 3'b100;
    step();
    chk("seq_gnt2", gnt, 3'b100);
    req = '0;
    k = 0;
    pixbad = 0;
    while (done == 3'b000 && k < 300) begin
      if (vga_x != 8'(20 + k % 10) || vga_y != 7'(30 + k / 10)) pixbad++;
      if (k == 10) req_x[23:16] = 8'd99;
      if (k == 50) begin
        set_req(0, 5, 6, 1);
        req[0] = 1'b1;
      end
      step();
      k++;
    end
    chk("seq_pixel_errors", pixbad, 0);
    chk("seq_done2_latency", k, 100);
    chk("seq_done2", done, 3'b100);
    step();
    chk("seq_gap_gnt", gnt, 0);
    step();
    chk("seq_gnt0", gnt, 3'b001);
    req = '0;
    wait_idle();
    step();

    // Leaves P at 2 so the reset-clears-P check below can tell.
    run_vec(vecs[2]);

    // Reset in the middle of a draw of requester 2.
    set_req(2, 10, 10, 3);
    set_req(1, 40, 40, 6);
    req = 3'b100;
    step();
    chk("rst_seq_gnt2", gnt, 3'b100);
    req = '0;
    repeat (40) step();
    chk("rst_seq_plot_before", plot, 1);
    Resetn = 1'b0;
    step();
    chk("rst_seq_plot", plot, 0);
    chk("rst_seq_busy", busy, 0);
    chk("rst_seq_done", done, 0);
    chk("rst_seq_vga_x", vga_x, 0);
    Resetn = 1'b1;
    req = 3'b110;
    step();
    chk("rst_seq_gnt1", gnt, 3'b010);
    req = '0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
